// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: fixed-latency loads/stores against a
// 64-bit-word backing store, with misalign/out-of-range flags, kill and nack.
module dmem_responder #(
  parameter int unsigned MEM_WORDS = 512,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dmem_req_valid_i,
  input  logic [4:0]  dmem_req_cmd_i,
  input  logic [39:0] dmem_req_addr_i,
  input  logic [2:0]  dmem_op_type_i,
  input  logic [63:0] dmem_req_data_i,
  input  logic [7:0]  dmem_req_tag_i,
  input  logic        dmem_req_kill_i,
  output logic        dmem_req_ready_o,
  output logic        dmem_resp_valid_o,
  output logic [63:0] dmem_resp_data_o,
  output logic [7:0]  dmem_resp_tag_o,
  output logic        dmem_resp_nack_o,
  output logic        dmem_resp_replay_o,
  output logic        dmem_xcpt_ma_ld_o,
  output logic        dmem_xcpt_ma_st_o,
  output logic        dmem_xcpt_pf_ld_o,
  output logic        dmem_xcpt_pf_st_o
);
  localparam int unsigned AW     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [4:0]  CMD_LD = 5'h00;
  localparam logic [4:0]  CMD_ST = 5'h01;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  cmd_q, cmd_d;
  logic [39:0] addr_q, addr_d;
  logic [2:0]  op_q, op_d;
  logic [63:0] data_q, data_d;
  logic [7:0]  tag_q, tag_d;
  logic        kill_win_q, kill_win_d;

  logic [63:0] mem_q [MEM_WORDS];

  logic          kill_now, supported, is_ld, is_st, ma, oor, fire, we;
  logic [AW-1:0] idx;
  logic [2:0]    off;
  logic [63:0]   rd_word, shifted, load_val, wdata;
  logic [7:0]    size_mask, lane_mask;
  logic          sext;

  assign idx = addr_q[AW+2:3];
  assign off = addr_q[2:0];

  always_comb begin
    kill_now  = kill_win_q & dmem_req_kill_i;
    is_ld     = (cmd_q == CMD_LD);
    is_st     = (cmd_q == CMD_ST);
    supported = is_ld | is_st;
    sext      = ~op_q[2];
    unique case (op_q[1:0])
      2'd0: begin ma = 1'b0;          size_mask = 8'h01; end
      2'd1: begin ma = addr_q[0];     size_mask = 8'h03; end
      2'd2: begin ma = |addr_q[1:0];  size_mask = 8'h0F; end
      default: begin ma = |addr_q[2:0]; size_mask = 8'hFF; end
    endcase
    oor       = (addr_q[39:3] >= 37'(MEM_WORDS));
    rd_word   = oor ? '0 : mem_q[idx];
    shifted   = rd_word >> {off, 3'b000};
    unique case (op_q[1:0])
      2'd0:    load_val = {{56{sext & shifted[7]}},  shifted[7:0]};
      2'd1:    load_val = {{48{sext & shifted[15]}}, shifted[15:0]};
      2'd2:    load_val = {{32{sext & shifted[31]}}, shifted[31:0]};
      default: load_val = shifted;
    endcase
    lane_mask = size_mask << off;
    wdata     = data_q << {off, 3'b000};
    // Kill lands in the cycle after acceptance, so it gates outputs combinationally
    // (relevant to the nack and to a LATENCY=1 response sharing that cycle).
    fire      = (state_q == RESP) & ~rst_i & ~kill_now;
    we        = fire & is_st & ~ma & ~oor;
  end

  assign dmem_req_ready_o   = (state_q == IDLE) & ~rst_i;
  assign dmem_resp_valid_o  = fire & supported;
  assign dmem_resp_nack_o   = fire & ~supported;
  assign dmem_resp_replay_o = 1'b0;
  assign dmem_resp_tag_o    = fire ? tag_q : '0;
  assign dmem_resp_data_o   = (dmem_resp_valid_o & is_ld & ~ma & ~oor) ? load_val : '0;
  assign dmem_xcpt_ma_ld_o  = dmem_resp_valid_o & is_ld & ma;
  assign dmem_xcpt_ma_st_o  = dmem_resp_valid_o & is_st & ma;
  assign dmem_xcpt_pf_ld_o  = dmem_resp_valid_o & is_ld & ~ma & oor;
  assign dmem_xcpt_pf_st_o  = dmem_resp_valid_o & is_st & ~ma & oor;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    op_d       = op_q;
    data_d     = data_q;
    tag_d      = tag_q;
    kill_win_d = 1'b0;
    unique case (state_q)
      IDLE: if (dmem_req_valid_i && dmem_req_ready_o) begin
        cmd_d      = dmem_req_cmd_i;
        addr_d     = dmem_req_addr_i;
        op_d       = dmem_op_type_i;
        data_d     = dmem_req_data_i;
        tag_d      = dmem_req_tag_i;
        kill_win_d = 1'b1;
        if (dmem_req_cmd_i == CMD_LD || dmem_req_cmd_i == CMD_ST) begin
          cnt_d   = 4'(LATENCY);
          state_d = (LATENCY > 1) ? WAIT : RESP;
        end else begin
          cnt_d   = '0;
          state_d = RESP;
        end
      end
      WAIT: begin
        if (kill_now) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd2) state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cmd_q      <= '0;
      addr_q     <= '0;
      op_q       <= '0;
      data_q     <= '0;
      tag_q      <= '0;
      kill_win_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      op_q       <= op_d;
      data_q     <= data_d;
      tag_q      <= tag_d;
      kill_win_q <= kill_win_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (lane_mask[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a byte-addressed reference memory predicts each
// response, expectations queue up at issue and are popped when the DUT answers.
module tb_dmem_responder;
  localparam int unsigned MEM_WORDS = 512;
  localparam int unsigned LAT       = 2;

  logic        clk, rst;
  logic        req_valid, req_kill, req_ready;
  logic [4:0]  req_cmd;
  logic [39:0] req_addr;
  logic [2:0]  op_type;
  logic [63:0] req_data, resp_data;
  logic [7:0]  req_tag, resp_tag;
  logic        resp_valid, resp_nack, resp_replay;
  logic        ma_ld, ma_st, pf_ld, pf_st;

  dmem_responder #(.MEM_WORDS(MEM_WORDS), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rst),
    .dmem_req_valid_i(req_valid), .dmem_req_cmd_i(req_cmd), .dmem_req_addr_i(req_addr),
    .dmem_op_type_i(op_type), .dmem_req_data_i(req_data), .dmem_req_tag_i(req_tag),
    .dmem_req_kill_i(req_kill), .dmem_req_ready_o(req_ready),
    .dmem_resp_valid_o(resp_valid), .dmem_resp_data_o(resp_data), .dmem_resp_tag_o(resp_tag),
    .dmem_resp_nack_o(resp_nack), .dmem_resp_replay_o(resp_replay),
    .dmem_xcpt_ma_ld_o(ma_ld), .dmem_xcpt_ma_st_o(ma_st),
    .dmem_xcpt_pf_ld_o(pf_ld), .dmem_xcpt_pf_st_o(pf_st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  // flags: {valid, nack, ma_ld, ma_st, pf_ld, pf_st, replay}
  typedef struct {
    logic [6:0]  flags;
    logic [63:0] data;
    logic [7:0]  tag;
    int unsigned cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] bm [logic [39:0]];
  int         checks = 0;
  int         fails  = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [4:0] cmd, input logic [39:0] addr,
                                 input logic [2:0] op, input logic [63:0] data,
                                 input logic [7:0] tag, input bit kill, input int unsigned acc);
    exp_t        e;
    int unsigned n;
    bit          ma, pf;
    logic [63:0] v;
    logic [39:0] a;
    n  = 1 << op[1:0];
    ma = (addr % n) != 0;
    pf = !ma && ((addr >> 3) >= MEM_WORDS);
    e.tag  = tag;
    e.data = '0;
    if (cmd > 5'h01) begin
      e.flags = 7'b0100000;
      e.cyc   = acc + 1;
    end else begin
      e.cyc   = acc + LAT;
      e.flags = {1'b1, 1'b0, ma && cmd == 0, ma && cmd == 1, pf && cmd == 0, pf && cmd == 1, 1'b0};
      if (!ma && !pf) begin
        if (cmd == 5'h00) begin
          v = '0;
          for (int i = 0; i < n; i++) begin
            a = 40'(addr + i);
            v[8*i +: 8] = bm.exists(a) ? bm[a] : 8'h00;
          end
          if (!op[2] && n < 8 && v[8*n-1]) for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
          e.data = v;
        end else if (!kill) begin
          for (int i = 0; i < n; i++) bm[40'(addr + i)] = data[8*i +: 8];
        end
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (resp_valid || resp_nack) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", {resp_valid, resp_nack}, 2'b00);
      end else begin
        e = sb.pop_front();
        chk("resp_flags", {resp_valid, resp_nack, ma_ld, ma_st, pf_ld, pf_st, resp_replay}, e.flags);
        chk("resp_data", resp_data, e.data);
        chk("resp_tag", resp_tag, e.tag);
        chk("resp_cycle", cyc, e.cyc);
      end
    end else begin
      chk("idle_data", resp_data, '0);
      chk("idle_misc", {resp_replay, ma_ld, ma_st, pf_ld, pf_st, resp_tag}, '0);
    end
  end

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic req(input logic [4:0] cmd, input logic [39:0] addr, input logic [2:0] op,
                     input logic [63:0] data, input logic [7:0] tag, input bit kill);
    exp_t e;
    @(posedge clk); #1;
    chk("ready_before_req", req_ready, 1);
    req_valid = 1'b1; req_cmd = cmd; req_addr = addr; op_type = op;
    req_data = data; req_tag = tag;
    e = model(cmd, addr, op, data, tag, kill, cyc);
    if (!kill) sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_data  = 64'hDEAD_BEEF_0BAD_F00D;
    if (kill) begin
      req_kill = 1'b1;
      @(posedge clk); #1;
      req_kill = 1'b0;
      chk("ready_after_kill", req_ready, 1);
    end
    drain();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    rst = 1'b1; req_valid = 1'b0; req_kill = 1'b0; req_cmd = '0; req_addr = '0;
    op_type = '0; req_data = '0; req_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", req_ready, 0);
    chk("reset_resp", {resp_valid, resp_nack}, 0);
    @(posedge clk); #1 rst = 1'b0;

    req(5'h01, 40'h40, 3'd3, 64'h1122334455667788, 8'h01, 0);
    req(5'h00, 40'h40, 3'd3, '0, 8'h5A, 0);
    req(5'h01, 40'h47, 3'd0, 64'h80, 8'h02, 0);
    req(5'h00, 40'h47, 3'd0, '0, 8'h03, 0);
    req(5'h00, 40'h47, 3'd4, '0, 8'h04, 0);
    req(5'h00, 40'h46, 3'd1, '0, 8'h05, 0);
    req(5'h00, 40'h44, 3'd6, '0, 8'h06, 0);
    req(5'h00, 40'h42, 3'd2, '0, 8'h07, 0);
    req(5'h01, 40'h43, 3'd1, 64'hFFFF, 8'h08, 0);
    req(5'h00, 40'h40, 3'd3, '0, 8'h09, 0);
    req(5'h01, 40'h40, 3'd3, 64'hCAFEF00DCAFEF00D, 8'h0A, 1);
    req(5'h00, 40'h40, 3'd3, '0, 8'h0B, 0);
    req(5'h07, 40'h40, 3'd3, '0, 8'h99, 0);
    req(5'h00, 40'(MEM_WORDS * 8), 3'd3, '0, 8'h0C, 0);
    req(5'h01, 40'(MEM_WORDS * 8), 3'd3, 64'h1, 8'h0D, 0);
    req(5'h00, 40'(MEM_WORDS * 8 + 1), 3'd1, '0, 8'h0E, 0);
    req(5'h01, 40'((MEM_WORDS - 1) * 8), 3'd3, 64'hA5A5_5A5A_0F0F_F0F0, 8'h0F, 0);
    req(5'h00, 40'((MEM_WORDS - 1) * 8 + 4), 3'd2, '0, 8'h10, 0);

    // reset while a store is waiting: outputs drop at once, store never lands
    req(5'h01, 40'h48, 3'd3, 64'h0123456789ABCDEF, 8'h11, 0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_cmd = 5'h01; req_addr = 40'h48; op_type = 3'd3;
    req_data = 64'hFFFF_FFFF_FFFF_FFFF; req_tag = 8'h12;
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b1;
    #1;
    chk("rst_mid_ready", req_ready, 0);
    chk("rst_mid_outs", {resp_valid, resp_nack, resp_replay, ma_ld, ma_st, pf_ld, pf_st, resp_tag}, '0);
    chk("rst_mid_data", resp_data, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    req(5'h00, 40'h48, 3'd3, '0, 8'h13, 0);

    // a store held valid while busy must be ignored
    req(5'h01, 40'h50, 3'd3, 64'h5555AAAA5555AAAA, 8'h14, 0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_cmd = 5'h00; req_addr = 40'h50; op_type = 3'd3; req_tag = 8'h15;
    e = model(5'h00, 40'h50, 3'd3, '0, 8'h15, 0, cyc);
    sb.push_back(e);
    @(posedge clk); #1;
    req_cmd = 5'h01; req_data = 64'h0BAD0BAD0BAD0BAD; req_tag = 8'h77;
    chk("busy_ready_wait", req_ready, 0);
    @(posedge clk); #1;
    chk("busy_ready_resp", req_ready, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain();
    req(5'h00, 40'h50, 3'd3, '0, 8'h16, 0);

    repeat (4) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 512, giving the number of 64-bit backing-store words.
REQ-002 SHALL have parameter LATENCY, default 2, giving the number of cycles from acceptance to response; legal range 1..15.
REQ-003 SHALL have port clk_i  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port dmem_req_valid_i  input  1  request present.
REQ-006 SHALL have port dmem_req_cmd_i  input  5  command: 5'h00 load, 5'h01 store; all other values unsupported.
REQ-007 SHALL have port dmem_req_addr_i  input  40  byte address.
REQ-008 SHALL have port dmem_op_type_i  input  3  size in bits [1:0] (0 byte, 1 half, 2 word, 3 double); bit [2] selects zero-extend on loads.
REQ-009 SHALL have port dmem_req_data_i  input  64  store data, LSB-aligned.
REQ-010 SHALL have port dmem_req_tag_i  input  8  request tag.
REQ-011 SHALL have port dmem_req_kill_i  input  1  cancels the request accepted in the previous cycle.
REQ-012 SHALL have port dmem_req_ready_o  output  1  the block can accept a request this cycle.
REQ-013 SHALL have port dmem_resp_valid_o  output  1  one-cycle response pulse.
REQ-014 SHALL have port dmem_resp_data_o  output  64  load result, extended to 64 bits.
REQ-015 SHALL have port dmem_resp_tag_o  output  8  tag of the request being answered.
REQ-016 SHALL have port dmem_resp_nack_o  output  1  one-cycle pulse rejecting an unsupported command.
REQ-017 SHALL have port dmem_resp_replay_o  output  1  tied to 0.
REQ-018 SHALL have ports dmem_xcpt_ma_ld_o, dmem_xcpt_ma_st_o, dmem_xcpt_pf_ld_o, dmem_xcpt_pf_st_o  output  1 each  misaligned-access and out-of-range flags, valid only with dmem_resp_valid_o.

Function
REQ-019 SHALL implement an FSM with states IDLE, WAIT and RESP; dmem_req_ready_o SHALL be 1 only in IDLE while rst_i=0.
REQ-020 SHALL accept a request when valid and ready are both 1, latching cmd, addr, op_type, data and tag, and SHALL leave IDLE on the next cycle.
REQ-021 An unsupported cmd SHALL produce dmem_resp_nack_o=1 with dmem_resp_valid_o=0 in the cycle after acceptance, then return to IDLE without any memory access.
REQ-022 For a supported cmd, a down-counter SHALL be loaded with LATENCY; dmem_resp_valid_o SHALL pulse for exactly one cycle, LATENCY cycles after the acceptance cycle, in state RESP.
REQ-023 dmem_req_kill_i=1 in the cycle after acceptance SHALL cancel the request: no response, no nack, no memory write; state returns to IDLE next cycle. Kill in any other cycle SHALL be ignored.
REQ-024 Misaligned access is addr not a multiple of 2^size; it SHALL set xcpt_ma_ld or xcpt_ma_st on the response with data 0 and no write.
REQ-025 Out-of-range is addr[39:3] >= MEM_WORDS; it SHALL set xcpt_pf_ld or xcpt_pf_st with data 0 and no write. If both conditions hold, ma SHALL take priority and pf SHALL stay 0.
REQ-026 A load SHALL read the word addr[39:3], select the byte lane at addr[2:0], then sign-extend, or zero-extend when op_type[2]=1.
REQ-027 A store SHALL write the low 2^size bytes of data into the addressed lanes only, in the response cycle; its response data SHALL be 0.
REQ-028 dmem_resp_tag_o SHALL equal the latched tag whenever valid or nack is 1, and SHALL be 0 otherwise.
REQ-029 In the RESP cycle ready SHALL be 0; ready SHALL return to 1 in the following cycle, so there is at most one outstanding request.
REQ-030 Requests presented while ready=0 SHALL be ignored and SHALL have no side effects.

Reset
REQ-031 While rst_i=1 the FSM SHALL be IDLE, the counter 0, and every output 0 including dmem_req_ready_o.
REQ-032 Asserting rst_i mid-operation SHALL abandon the pending request: a pending store SHALL NOT write, and no response SHALL follow. Memory contents are not reset.

Verification
REQ-033 Store 0x1122334455667788 double to 0x40, then load double from 0x40 with tag 0x5A (LATENCY=2) -> resp_valid exactly 2 cycles after acceptance, data 0x1122334455667788, tag 0x5A.
REQ-034 Load byte from 0x47, signed, then unsigned -> data 0xFFFFFFFFFFFFFF80 and 0x80 respectively, after a prior store of 0x80 to 0x47.
REQ-035 Load word from 0x42 -> resp_valid with xcpt_ma_ld=1 and data 0; a store half to 0x43 -> xcpt_ma_st=1 and memory unchanged.
REQ-036 Store with kill asserted in the cycle after acceptance -> no resp_valid, ready=1 two cycles after acceptance, and a later load of that address returns the old value.
REQ-037 cmd=5'h07 -> nack=1 one cycle after acceptance, resp_valid=0; load to address MEM_WORDS*8 -> xcpt_pf_ld=1.
REQ-038 rst_i asserted during WAIT of a store -> all outputs 0, no response, and the store is not performed.
